// File: rtl/sync_debounce_edge_pkg.sv
// sync_pkg: shared types and helpers for sync_debounce_edge.
// Optional feature macro: SYNC_DEBOUNCE_GLITCH_CNT_EN (glitch counter).
package sync_pkg;

    localparam int GLITCH_CNT_W = 16;

    typedef logic [GLITCH_CNT_W-1:0] glitch_cnt_t;

    localparam glitch_cnt_t GLITCH_CNT_MAX = '1;

    // Effective per-channel condition for the current cycle.
    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,   // synchronized level equals accepted level
        CH_PENDING = 2'd1,   // new level seen, still maturing
        CH_ACCEPT  = 2'd2    // new level has been stable long enough
    } chan_state_e;

    // Width of a counter that must hold 0..filter_cycles.
    function automatic int cnt_width(input int filter_cycles);
        return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
    endfunction

    // Saturating accumulate of this cycle's glitch count.
    function automatic glitch_cnt_t glitch_sat_add(input glitch_cnt_t acc,
                                                   input int unsigned inc);
        int unsigned sum;
        sum = 32'(acc) + inc;
        return (sum > 32'(GLITCH_CNT_MAX)) ? GLITCH_CNT_MAX : glitch_cnt_t'(sum);
    endfunction

endpackage

// File: rtl/sync_debounce_edge_if.sv
// sync_debounce_edge_if: data-side signals of the input conditioner.
// Glitch counter signals exist only with SYNC_DEBOUNCE_GLITCH_CNT_EN.
interface sync_debounce_edge_if
    import sync_pkg::*;
#(
    parameter int SIZE = 1
);
    logic [SIZE-1:0] din;
    logic [SIZE-1:0] dout;
    logic [SIZE-1:0] rise;
    logic [SIZE-1:0] fall;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    glitch_cnt_t     glitch_cnt;
    logic            glitch_clr;

    modport master (output din, output glitch_clr,
                    input  dout, input rise, input fall, input glitch_cnt);
    modport slave  (input  din, input glitch_clr,
                    output dout, output rise, output fall, output glitch_cnt);
`else
    modport master (output din,
                    input  dout, input rise, input fall);
    modport slave  (input  din,
                    output dout, output rise, output fall);
`endif
endinterface

// File: rtl/sync_debounce_edge_chan.sv
// debounce_chan: one channel's stability counter, accepted level and
// registered rise/fall pulses. Glitch flag exists only with
// SYNC_DEBOUNCE_GLITCH_CNT_EN.
module debounce_chan
    import sync_pkg::*;
#(
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    output logic dout,
    output logic rise,
    output logic fall
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic glitch
`endif
);

    localparam int               CNT_W    = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    chan_state_e      state;

    // Classify the cycle from the synchronized level and the run counter.
    always_comb begin
        // NOTE: default assigned first so every path drives state; no latch.
        state = CH_IDLE;
        if (s != dout) begin
            state = (cnt_q == CNT_LAST) ? CH_ACCEPT : CH_PENDING;
        end
    end

    // Counter, accepted level and edge pulses, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
            dout  <= RESET_BIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                CH_PENDING: cnt_q <= cnt_q + 1'b1;
                CH_ACCEPT: begin
                    cnt_q <= '0;
                    dout  <= s;
                    rise  <= s;
                    fall  <= ~s;
                end
                default:    cnt_q <= '0;
            endcase
        end
    end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    // A run that was maturing fell back to the accepted level.
    assign glitch = (cnt_q != '0) && (s == dout);
`endif

endmodule

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: multi-channel synchronizer + debounce filter with
// single-cycle rise/fall pulses. Defining SYNC_DEBOUNCE_GLITCH_CNT_EN adds
// a saturating glitch counter with synchronous clear.
module sync_debounce_edge
    import sync_pkg::*;
#(
    parameter int              SIZE          = 1,
    parameter int              N_STAGE       = 2,
    parameter int              FILTER_CYCLES = 4,
    parameter logic [SIZE-1:0] RESET_VAL     = '0
) (
    input logic                 clk,
    input logic                 rst_n,
    sync_debounce_edge_if.slave bus
);

    (* ASYNC_REG = "TRUE" *) logic [SIZE-1:0] sync_q [N_STAGE];

    logic [SIZE-1:0] dout_w;
    logic [SIZE-1:0] rise_w;
    logic [SIZE-1:0] fall_w;

    // Plain flop chain bringing the asynchronous inputs into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the chain is a handful of flops, not RAM, so it is reset to a known level.
        if (!rst_n) begin
            for (int k = 0; k < N_STAGE; k++) sync_q[k] <= RESET_VAL;
        end else begin
            sync_q[0] <= bus.din;
            for (int k = 1; k < N_STAGE; k++) sync_q[k] <= sync_q[k-1];
        end
    end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic [SIZE-1:0] glitch_w;
    glitch_cnt_t     glitch_cnt_q;
`endif

    for (genvar g = 0; g < SIZE; g++) begin : g_chan
        debounce_chan #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_BIT     (RESET_VAL[g])
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .s      (sync_q[N_STAGE-1][g]),
            .dout   (dout_w[g]),
            .rise   (rise_w[g]),
            .fall   (fall_w[g])
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
            ,
            .glitch (glitch_w[g])
`endif
        );
    end

    assign bus.dout = dout_w;
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    // Accumulate this cycle's glitches; clear takes priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_q <= '0;
        end else if (bus.glitch_clr) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_sat_add(glitch_cnt_q, $countones(glitch_w));
        end
    end

    assign bus.glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge: directed scenarios plus random din against a
// window-based reference model. Glitch counter scenarios run only when
// SYNC_DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_sync_debounce_edge;
    import sync_pkg::*;

    localparam int              SIZE          = 4;
    localparam int              N_STAGE       = 2;
    localparam int              FILTER_CYCLES = 4;
    localparam logic [SIZE-1:0] RESET_VAL     = '0;
    localparam int              LATENCY       = N_STAGE + FILTER_CYCLES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sync_debounce_edge_if #(.SIZE(SIZE)) bus ();

    sync_debounce_edge #(
        .SIZE          (SIZE),
        .N_STAGE       (N_STAGE),
        .FILTER_CYCLES (FILTER_CYCLES),
        .RESET_VAL     (RESET_VAL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a din is seen by the filter N_STAGE edges later; a
    // channel flips when its last FILTER_CYCLES filter samples all differ
    // from the current output; a glitch is a sample back at the output level
    // directly after a sample that differed from it.
    logic [SIZE-1:0] pipe_q [$];
    logic [SIZE-1:0] win_q  [$];
    logic [SIZE-1:0] m_dout, m_rise, m_fall;
    glitch_cnt_t     m_gcnt;

    task automatic model_reset();
        pipe_q.delete();
        win_q.delete();
        for (int k = 0; k < N_STAGE; k++) pipe_q.push_back(RESET_VAL);
        for (int k = 0; k < FILTER_CYCLES; k++) win_q.push_back(RESET_VAL);
        m_dout = RESET_VAL;
        m_rise = '0;
        m_fall = '0;
        m_gcnt = '0;
    endtask

    task automatic model_step();
        logic [SIZE-1:0] s, prev, nd;
        int g;
        bit all_diff;
        s    = pipe_q.pop_front();
        pipe_q.push_back(bus.din);
        prev = win_q[$];
        win_q.push_back(s);
        void'(win_q.pop_front());
        nd = m_dout;
        m_rise = '0;
        m_fall = '0;
        g = 0;
        for (int ch = 0; ch < SIZE; ch++) begin
            all_diff = 1'b1;
            foreach (win_q[k]) if (win_q[k][ch] == m_dout[ch]) all_diff = 1'b0;
            if (all_diff) begin
                nd[ch] = ~m_dout[ch];
                if (nd[ch]) m_rise[ch] = 1'b1;
                else        m_fall[ch] = 1'b1;
            end
            if (s[ch] == m_dout[ch] && prev[ch] != m_dout[ch]) g++;
        end
        m_dout = nd;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        if (bus.glitch_clr)                   m_gcnt = '0;
        else if (int'(m_gcnt) + g > 16'hFFFF) m_gcnt = 16'hFFFF;
        else                                  m_gcnt = m_gcnt + glitch_cnt_t'(g);
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Continuous comparison against the model, plus output-run properties.
    int              run_len [SIZE];
    logic [SIZE-1:0] last_dout;

    always @(negedge clk) begin
        check("dout", bus.dout, m_dout);
        check("rise", bus.rise, m_rise);
        check("fall", bus.fall, m_fall);
        check("rise_and_fall", bus.rise & bus.fall, '0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt", bus.glitch_cnt, m_gcnt);
`endif
        for (int ch = 0; ch < SIZE; ch++) begin
            if (!rst_n) begin
                run_len[ch] = 0;
            end else if (bus.dout[ch] != last_dout[ch]) begin
                check($sformatf("run_len_ok[%0d]", ch), 32'(run_len[ch] >= FILTER_CYCLES), 1);
                run_len[ch] = 1;
            end else begin
                run_len[ch]++;
            end
        end
        last_dout = bus.dout;
    end

    // Count edges until the masked dout reaches target; bounded.
    task automatic wait_dout(input string tag, input logic [SIZE-1:0] mask,
                             input logic [SIZE-1:0] target, input int exp_edges);
        int n;
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            n++;
            #1;
            if ((bus.dout & mask) == (target & mask)) break;
        end
        check(tag, n, exp_edges);
    endtask

    task automatic reset_for(input int cycles);
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    // One-cycle din pulse on the masked channels, then let it drain.
    task automatic glitch_pulse(input logic [SIZE-1:0] mask);
        @(negedge clk);
        bus.din = bus.din | mask;
        @(negedge clk);
        bus.din = bus.din & ~mask;
        settle(6);
    endtask
`endif

    int hold [SIZE];

    initial begin
        glitch_cnt_t g0;
        bus.din = 4'hF;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        bus.glitch_clr = 1'b0;
`endif
        // Reset with all inputs high.
        settle(3);
        check("reset_dout", bus.dout, 4'h0);
        check("reset_rise", bus.rise, 4'h0);
        check("reset_fall", bus.fall, 4'h0);
        #2 rst_n = 1'b1;
        wait_dout("release_latency", 4'hF, 4'hF, LATENCY);
        check("release_rise", bus.rise, 4'hF);
        @(posedge clk);
        #1 check("release_rise_once", bus.rise, 4'h0);

        // Bring everything low, then a clean step on channel 0.
        @(negedge clk);
        bus.din = 4'h0;
        settle(12);
        bus.din = 4'h1;
        wait_dout("step_latency", 4'h1, 4'h1, LATENCY);
        check("step_rise0", bus.rise, 4'h1);
        check("step_fall0", bus.fall, 4'h0);
        @(negedge clk);
        bus.din = 4'h0;
        settle(12);

        // Short excursion on channel 1 must be rejected.
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        g0 = bus.glitch_cnt;
`else
        g0 = '0;
`endif
        bus.din = 4'h2;
        settle(3);
        bus.din = 4'h0;
        settle(10);
        check("glitch_dout1", bus.dout, 4'h0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt_plus1", bus.glitch_cnt, g0 + 16'd1);
        g0 = bus.glitch_cnt;
`endif
        // Three channels glitch together.
        bus.din = 4'hE;
        settle(2);
        bus.din = 4'h0;
        settle(10);
        check("glitch3_dout", bus.dout, 4'h0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt_plus3", bus.glitch_cnt, g0 + 16'd3);

        // Drive the counter near saturation by toggling every channel.
        begin
            int guard;
            guard = 0;
            while (m_gcnt < 16'hFFF0 && guard < 40000) begin
                @(negedge clk);
                bus.din = ~bus.din;
                guard++;
            end
            check("preload_reached", 32'(m_gcnt >= 16'hFFF0), 1);
            bus.din = 4'h0;
            settle(10);
            guard = 0;
            while (m_gcnt < 16'hFFFE && guard < 40) begin
                glitch_pulse(4'h1);
                guard++;
            end
        end
        check("preload_fffe", bus.glitch_cnt, 16'hFFFE);
        glitch_pulse(4'hE);
        check("saturate", bus.glitch_cnt, 16'hFFFF);

        // Clear coincides with a three-channel glitch: clear wins.
        @(negedge clk);
        bus.din = 4'hE;
        @(negedge clk);
        bus.din = 4'h0;
        @(negedge clk);
        @(negedge clk);
        bus.glitch_clr = 1'b1;
        @(negedge clk);
        bus.glitch_clr = 1'b0;
        settle(6);
        check("clear_wins", bus.glitch_cnt, 16'h0000);
`endif

        // Reset while channel 2 is three counts into a pending transition.
        @(negedge clk);
        bus.din = 4'h4;
        settle(5);
        #2 rst_n = 1'b0;
        settle(2);
        check("midreset_dout", bus.dout, 4'h0);
        #2 rst_n = 1'b1;
        wait_dout("midreset_latency", 4'h4, 4'h4, LATENCY);
        check("midreset_rise2", bus.rise, 4'h4);

        // Random mixed-length pulses per channel with occasional resets.
        @(negedge clk);
        for (int ch = 0; ch < SIZE; ch++) hold[ch] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int ch = 0; ch < SIZE; ch++) begin
                if (hold[ch] == 0) begin
                    bus.din[ch] = ~bus.din[ch];
                    hold[ch] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FILTER_CYCLES - 2))
                                                          : int'($urandom_range(FILTER_CYCLES, 3 * FILTER_CYCLES));
                end else begin
                    hold[ch]--;
                end
            end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
            bus.glitch_clr = ($urandom_range(0, 49) == 0);
`endif
            if ($urandom_range(0, 1499) == 0) reset_for(2);
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        bus.glitch_clr = 1'b0;
`endif
        settle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sync_debounce_edge.md
# sync_debounce_edge

Multi-channel asynchronous-input conditioner: each bit of `din` passes through an N_STAGE metastability synchronizer, then a per-channel debounce filter that accepts a new level only after it has been stable for FILTER_CYCLES consecutive clocks. Single-cycle rise and fall pulses accompany each accepted transition. It sits at the boundary where pins, or signals from unrelated clock domains, enter the `clk` domain, e.g. FIFO flush/enable requests and external status lines. Bits are handled independently; no inter-bit coherency is provided.

## Interface
- SIZE, 1: number of independent channels.
- N_STAGE, 2: synchronizer flops per channel, ≥2.
- FILTER_CYCLES, 4: consecutive stable cycles needed to accept a level, ≥1.
- RESET_VAL, '0: SIZE-bit reset level for the synchronizer flops and `dout`.
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  SIZE  asynchronous inputs, no timing relation to `clk`.
- dout  out  SIZE  filtered, synchronous level.
- rise  out  SIZE  one-cycle pulse per channel on an accepted 0→1.
- fall  out  SIZE  one-cycle pulse per channel on an accepted 1→0.
- glitch_cnt  out  16  present only with SYNC_DEBOUNCE_GLITCH_CNT_EN.
- glitch_clr  in  1  present only with SYNC_DEBOUNCE_GLITCH_CNT_EN.

## Operation
- Synchronizer: `s[i]` is the output of an N_STAGE flop chain. All chain flops carry ASYNC_REG and have no logic between them.
- Per-channel counter `cnt[i]` is $clog2(FILTER_CYCLES+1) bits wide and resets to 0.
  - If `s[i] == dout[i]`: `cnt[i]` ← 0.
  - Else if `cnt[i] == FILTER_CYCLES-1`: `dout[i]` ← `s[i]`, `cnt[i]` ← 0.
  - Else: `cnt[i]` ← `cnt[i]+1`.
- A channel holds one of three effective states:
  - IDLE: cnt=0 and s==dout.
  - PENDING: s≠dout.
  - ACCEPT: the cycle the counter matures.
- `rise[i]`/`fall[i]` are registered. They are high for exactly the first cycle in which the new `dout[i]` is visible, and are never both high on the same channel.
- Glitch: a channel with `cnt[i]≠0` sees `s[i]==dout[i]` again. The counter restarts and `dout` is unchanged.
- Reset:
  - Asserted: sync flops and `dout` = RESET_VAL; `cnt`, `rise`, `fall` = 0; glitch_cnt = 0.
  - Release: no pulses if `din` already equals RESET_VAL. Otherwise the normal filtered transition occurs.
  - Reset mid-PENDING discards the pending transition.

## Timing
- `din` step, stable thereafter → `s` changes after N_STAGE edges (±1 for sampling uncertainty).
- `dout`/pulse change FILTER_CYCLES edges after `s` changes.
- Total latency is N_STAGE+FILTER_CYCLES edges (+1 uncertainty).
- Rejection: any excursion of `s` lasting < FILTER_CYCLES cycles never reaches `dout`.
- Minimum accepted pulse width at `dout` is FILTER_CYCLES cycles.
- FILTER_CYCLES=1: `dout` follows `s` with 1 cycle delay; no filtering.
- All outputs are driven straight from flops.

## Configuration
- `SYNC_DEBOUNCE_GLITCH_CNT_EN` defined:
  - Adds `glitch_cnt` and `glitch_clr`.
  - Each cycle, `glitch_cnt` adds the number of channels detecting a glitch that cycle (popcount, 0..SIZE) and saturates at 16'hFFFF.
  - `glitch_clr`=1 loads 0. If clear and increment coincide, clear wins; that cycle's glitches are dropped.
- Not defined: ports and counter are absent; all other behaviour is identical.

## Structure
- Package `sync_pkg`:
  - `GLITCH_CNT_W = 16`.
  - Function `cnt_width(FILTER_CYCLES)`.
  - Typedef `glitch_cnt_t`.
- Sub-module `debounce_chan`: one channel's counter, `dout` flop and rise/fall flops, instanced SIZE times by a generate loop. The top holds the synchronizer chains and the glitch popcount/accumulator.

## Test plan
- Reset: rst_n=0 with din=4'hF, SIZE=4, RESET_VAL=0 → dout=0, rise=fall=0. After release with din held, dout=4'hF at edge 2+4(+1), with rise=4'hF for exactly one cycle.
- Clean step: N_STAGE=2, FILTER_CYCLES=4, din[0] 0→1 → dout[0]=1 after 6 (±1) edges; single rise[0] pulse; fall stays 0.
- Glitch: din[1] high for 3 cycles then low (FILTER_CYCLES=4) → dout[1] never changes, no pulses. With the macro on, glitch_cnt=1.
- Simultaneous glitches: 3 channels glitch in the same cycle → glitch_cnt increments by 3. Preload near 16'hFFFE, glitch 3 → 16'hFFFF. glitch_clr with a coincident glitch → 0.
- Mid-operation reset: assert rst_n while cnt[2]=3 → cnt cleared, dout[2]=RESET_VAL. After release the full latency is required again.
- Random async `din` with mixed long and short pulses against a reference model: rise/fall each one cycle, never both high on a channel, and every dout run length ≥ FILTER_CYCLES.
